fir_mac_core: RTL and testbench
===============================

// Module: fir_mac_core
// PURPOSE
//  Time-multiplexed N-tap FIR engine driven by the wishbone register slave. Holds the
//  coefficient bank and sample delay line, and runs one signed Q1.15 multiply-accumulate per clock.
//  Returns a rounded, saturated result to the slave on the same result bus it reads.
//  A single shared MAC replaces N parallel multipliers.
// PARAMETERS
//  N          4                    number of taps (1..15; addr_coeff is 4 bits)
//  DATA_WIDTH 16                   sample/coefficient/result width, signed two's complement
//  FRAC_BITS  15                   fractional bits of coefficients (Q1.15)
//  ACC_WIDTH  2*DATA_WIDTH+$clog2(N)+1  accumulator width; must not overflow internally
// PORTS
//  clk_i         in   1    clock, all state updates on rising edge
//  rst_i         in   1    reset, synchronous, active-high
//  we_coeff      in   1    one-cycle write strobe for the coefficient bank
//  addr_coeff    in   4    coefficient index for writes and reads
//  data_coeff_i  in   DW   coefficient write data
//  data_coeff_o  out  DW   coeff[addr_coeff], combinational; 0 if addr_coeff >= N
//  valid         in   1    one-cycle new-sample strobe
//  sample        in   DW   new input sample, qualified by valid
//  result        out  DW   last filter output, held until the next completion
//  result_valid  out  1    one-cycle pulse when result updates
//  busy          out  1    high while a computation is in progress
//  overrun       out  1    sticky; set when valid is dropped; cleared only by rst_i
// BEHAVIOUR
//  Reset (sync, rst_i=1 at edge) applies to state=IDLE, all coeff[], delay[], acc, tap counter,
//   result, result_valid, busy and overrun, which all go to 0. Reset overrides any activity in the same cycle.
//  Coefficient write: we_coeff=1 with addr_coeff<N -> coeff[addr]<=data_coeff_i at the same edge.
//   addr>=N is ignored. Writes are accepted in every state, and the MAC reads coeff[] live,
//   so a write during MAC affects only taps not yet consumed.
//  FSM states: IDLE -> MAC -> OUT -> IDLE.
//   IDLE: valid=1 -> delay[0]<=sample, delay[i]<=delay[i-1], acc<=0, tap<=0, busy<=1, go MAC.
//   MAC: acc<=acc+sext(delay[tap]*coeff[tap]); tap++. After tap N-1, go OUT (N cycles).
//   OUT: result<=sat(round(acc)), result_valid<=1 for one cycle, busy<=0, go IDLE.
//  Latency: if valid is sampled at edge k, result and result_valid update at edge k+N+1.
//   busy is high over edges k..k+N. Maximum throughput is one sample per N+2 cycles.
//  valid while busy (MAC/OUT): the sample is dropped, the delay line is unchanged, and overrun<=1.
//   valid in the same cycle as the OUT->IDLE transition is also dropped.
//  Arithmetic: the product is a 2*DW signed full product; acc is ACC_WIDTH signed.
//   round = (acc + 2**(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up).
//   sat clamps to [-2**(DW-1), 2**(DW-1)-1], i.e. 0x8000..0x7FFF for DW=16.
//  Reset mid-MAC: the computation is aborted, there is no result_valid pulse, and result reads 0 after reset.
// STRUCTURE
//  fir_pkg: state encoding (IDLE/MAC/OUT), default N/DATA_WIDTH/FRAC_BITS, sat function.
//   The wishbone slave shares N and DATA_WIDTH from this package.
//  Sub-module fir_mac_unit: product, accumulate, clear, and round/saturate output,
//   with no FSM. The FSM, delay line and coefficient bank stay in fir_mac_core.
// TESTING
//  1 Release reset, read addr 0..N-1 and 7 -> data_coeff_o=0; result=0, busy=0, overrun=0.
//  2 Write coeff[0..3]=0x4000, push samples 0x7FFF,0,0,0,0, each after busy drops ->
//    results 0x4000,0x4000,0x4000,0x4000,0x0000; result_valid exactly N+1 edges after each valid.
//  3 Write coeff[0..3]=0x7FFF, push 0x7FFF x4 -> final result 0x7FFF (saturated).
//    Then push 0x8000 x4 -> final result 0x8000.
//  4 Push valid, then assert valid again 2 cycles later -> second sample dropped,
//    overrun=1 and stays 1, next result reflects only the first sample.
//  5 Write addr 5 = 0x1234 -> no bank change and read addr 5 = 0; write addr 2 = 0xABCD -> read addr 2 = 0xABCD.
//  6 Assert rst_i one cycle during MAC -> no result_valid, busy=0, result=0, and coeffs read 0 at the next edge.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engine: default geometry, FSM encoding and
// the output saturation helper. The wishbone slave imports N and DATA_WIDTH
// from here so both sides agree on the bank size and bus width.
package fir_pkg;

  localparam int FIR_N          = 4;
  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_FRAC_BITS  = 15;

  // Wide intermediate used by the saturation helper; any accumulator
  // narrower than this is sign-extended into it before clamping.
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Clamp a signed value to the signed DATA_WIDTH range.
  function automatic logic [FIR_DATA_WIDTH-1:0] sat_dw(input logic signed [SAT_IN_W-1:0] v);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (FIR_DATA_WIDTH - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (FIR_DATA_WIDTH - 1));
    if (v > hi) begin
      sat_dw = hi[FIR_DATA_WIDTH-1:0];
    end else if (v < lo) begin
      sat_dw = lo[FIR_DATA_WIDTH-1:0];
    end else begin
      sat_dw = v[FIR_DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate datapath. Holds only the accumulator;
// sequencing (clear / enable) comes from the owning FSM. The rounded and
// saturated view of the accumulator is presented combinationally so the
// owner can capture it in the cycle after the last tap.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int FRAC_BITS  = FIR_FRAC_BITS,
  parameter int ACC_WIDTH  = 2*FIR_DATA_WIDTH + 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic        [DATA_WIDTH-1:0] res_o
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] RND_CONST = ACC_WIDTH'(1) << (FRAC_BITS - 1);

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] acc_rnd;
  logic signed [ACC_WIDTH-1:0] acc_shr;
  logic signed [SAT_IN_W-1:0]  acc_wide;

  // Full-precision signed product, sign-extended to the accumulator width.
  always_comb begin
    prod     = a_i * b_i;
    prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Accumulator next value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Round half up at the binary point, then clamp to the output range.
  always_comb begin
    acc_rnd  = acc_q + RND_CONST;
    acc_shr  = acc_rnd >>> FRAC_BITS;
    acc_wide = {{(SAT_IN_W - ACC_WIDTH){acc_shr[ACC_WIDTH-1]}}, acc_shr};
    res_o    = sat_dw(acc_wide);
  end

endmodule

// File: rtl/fir_mac_core.sv
// Time-multiplexed N-tap FIR: coefficient bank, sample delay line and a
// three-state sequencer driving one shared MAC. One tap per clock.
//
// Sample handshake: valid is a single-cycle strobe with no back-pressure.
// The core accepts it only in IDLE (busy low); any valid seen while busy is
// high (MAC or OUT) is discarded and latches the sticky overrun flag.
module fir_mac_core
  import fir_pkg::*;
#(
  parameter int N          = FIR_N,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int FRAC_BITS  = FIR_FRAC_BITS,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_coeff,
  input  logic [3:0]            addr_coeff,
  input  logic [DATA_WIDTH-1:0] data_coeff_i,
  output logic [DATA_WIDTH-1:0] data_coeff_o,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overrun,
  output fir_state_e            dbg_state_o
);

  localparam int TAP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N - 1);

  fir_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] coeff_q [N];
  logic [DATA_WIDTH-1:0] coeff_d [N];
  logic [DATA_WIDTH-1:0] delay_q [N];
  logic [DATA_WIDTH-1:0] delay_d [N];
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  start, mac_en, finish, drop;
  logic                  addr_in_range;
  logic [TAP_W-1:0]      addr_idx;
  logic [DATA_WIDTH-1:0] mac_a, mac_b, mac_res;

  // Address decode shared by the write port and the combinational read port.
  always_comb begin
    addr_in_range = int'(addr_coeff) < N;
    addr_idx      = addr_coeff[TAP_W-1:0];
    data_coeff_o  = addr_in_range ? coeff_q[addr_idx] : '0;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept in IDLE, run N taps, one cycle to publish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (valid) state_d = ST_MAC;
      ST_MAC:  if (tap_q == LAST_TAP) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-state control strobes for the datapath.
  always_comb begin
    start  = 1'b0;
    mac_en = 1'b0;
    finish = 1'b0;
    case (state_q)
      ST_IDLE: start  = valid;
      ST_MAC:  mac_en = 1'b1;
      ST_OUT:  finish = 1'b1;
      default: ;
    endcase
    drop = valid && (state_q != ST_IDLE);
  end

  // Datapath next values: coefficient writes are live in every state, the
  // delay line only shifts when a sample is accepted.
  always_comb begin
    coeff_d        = coeff_q;
    delay_d        = delay_q;
    tap_d          = tap_q;
    result_d       = result_q;
    result_valid_d = finish;
    busy_d         = busy_q;
    overrun_d      = overrun_q | drop;
    if (we_coeff && addr_in_range) begin
      coeff_d[addr_idx] = data_coeff_i;
    end
    if (start) begin
      delay_d[0] = sample;
      for (int i = 1; i < N; i++) begin
        delay_d[i] = delay_q[i-1];
      end
      tap_d  = '0;
      busy_d = 1'b1;
    end
    if (mac_en) begin
      tap_d = tap_q + TAP_W'(1);
    end
    if (finish) begin
      result_d = mac_res;
      busy_d   = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coeff_q        <= '{default: '0};
      delay_q        <= '{default: '0};
      tap_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      coeff_q        <= coeff_d;
      delay_q        <= delay_d;
      tap_q          <= tap_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  // MAC operand select: the tap currently being consumed, coefficient read live.
  always_comb begin
    mac_a = delay_q[tap_q];
    mac_b = coeff_q[tap_q];
  end

  fir_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (start),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .res_o (mac_res)
  );

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fir_mac_core.sv
// Bench for fir_mac_core: directed scenarios plus a randomized run, all
// checked against a tap-sum reference model of the filter.
module tb_fir_mac_core;
  import fir_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 60;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          we_coeff = 1'b0;
  logic [3:0]    addr_coeff = '0;
  logic [DW-1:0] data_coeff_i = '0;
  logic [DW-1:0] data_coeff_o;
  logic          valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          overrun;
  fir_state_e    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state and scoreboard
  int            m_coeff [N];
  int            m_delay [N];
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];

  fir_mac_core dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .we_coeff     (we_coeff),
    .addr_coeff   (addr_coeff),
    .data_coeff_i (data_coeff_i),
    .data_coeff_o (data_coeff_o),
    .valid        (valid),
    .sample       (sample),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state_o  (dbg_state)
  );

  // clock / cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // y = round_half_up(sum(x[i]*c[i]) / 2^15), clamped to 16-bit signed
  function automatic logic [DW-1:0] model_out();
    longint s = 0;
    longint q;
    logic [63:0] qv;
    for (int i = 0; i < N; i++) s += longint'(m_delay[i]) * longint'(m_coeff[i]);
    q = s + 16384;
    if (q >= 0) q = q / 32768;
    else q = -((-q + 32767) / 32768);   // floor for negatives
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    qv = q;
    return qv[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_coeff(input int addr);
    logic [31:0] v;
    if (addr >= N) return '0;
    v = m_coeff[addr];
    return v[DW-1:0];
  endfunction

  // scoreboard monitor: sample #1 after each active edge
  always @(posedge clk_i) begin
    #1;
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 64'(result_valid), 64'd0);
      end else begin
        chk("result", 64'(result), 64'(exp_q.pop_front()));
        chk("latency", 64'(cyc - lat_q.pop_front()), 64'(N + 1));
      end
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic write_coeff(input int addr, input logic [DW-1:0] d);
    @(negedge clk_i);
    we_coeff = 1'b1; addr_coeff = 4'(addr); data_coeff_i = d;
    if (addr < N) m_coeff[addr] = int'($signed(d));
    @(negedge clk_i);
    we_coeff = 1'b0;
  endtask

  task automatic read_check(input int addr);
    @(negedge clk_i);
    addr_coeff = 4'(addr);
    #1;
    chk("coeff_read", 64'(data_coeff_o), 64'(model_coeff(addr)));
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk_i);
    while (busy && t < TO) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= TO) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic push(input logic [DW-1:0] s);
    wait_idle();
    valid = 1'b1; sample = s;
    lat_q.push_back(cyc + 1);
    for (int i = N - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
    m_delay[0] = int'($signed(s));
    exp_q.push_back(model_out());
    @(negedge clk_i);
    valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < TO) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= TO) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_coeff[i] = 0;
      m_delay[i] = 0;
    end
    exp_q.delete();
    lat_q.delete();
  endtask

  initial begin
    model_reset();
    // reset
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // 1: post-reset state
    for (int a = 0; a < N; a++) read_check(a);
    read_check(7);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // 2: impulse through a 0.5 bank
    for (int a = 0; a < N; a++) write_coeff(a, 16'h4000);
    push(16'h7FFF);
    for (int i = 0; i < 4; i++) push(16'h0000);
    drain();
    chk("impulse_tail", 64'(result), 64'h0000);
    chk("no_overrun_yet", 64'(overrun), 64'd0);

    // 3: positive and negative saturation
    for (int a = 0; a < N; a++) write_coeff(a, 16'h7FFF);
    for (int i = 0; i < 4; i++) push(16'h7FFF);
    drain();
    chk("sat_pos", 64'(result), 64'h7FFF);
    for (int i = 0; i < 4; i++) push(16'h8000);
    drain();
    chk("sat_neg", 64'(result), 64'h8000);

    // 4: a second strobe while busy is dropped
    write_coeff(0, 16'h2000);
    push(16'h1111);
    @(negedge clk_i);
    valid = 1'b1; sample = 16'h5555;
    @(negedge clk_i);
    valid = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    drain();
    push(16'h0123);
    drain();
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // 5: out-of-range writes are ignored
    write_coeff(5, 16'h1234);
    read_check(5);
    for (int a = 0; a < N; a++) read_check(a);
    write_coeff(2, 16'hABCD);
    read_check(2);

    // randomized run
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        write_coeff($urandom_range(0, 7), 16'($urandom));
      end
      if ($urandom_range(0, 3) == 0) read_check($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: push(16'h7FFF);
        1: push(16'h8000);
        default: push(16'($urandom));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    drain();

    // 6: reset in the middle of a computation
    push(16'($urandom_range(1, 16'h7FFF)));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_overrun", 64'(overrun), 64'd0);
    chk("midrst_rv", 64'(result_valid), 64'd0);
    for (int a = 0; a < N; a++) read_check(a);
    repeat (N + 4) @(negedge clk_i);
    chk("midrst_result_hold", 64'(result), 64'd0);

    // filter still usable after reset
    write_coeff(1, 16'h4000);
    push(16'h1000);
    push(16'h2000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
